// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART transmit FIFO and its storage block.
// Contents: default FIFO depth, 2-bit encodings of the serializer handshake FSM.
// No logic; imported with import uart_pkg::*.
package uart_pkg;

  localparam int UART_FIFO_DEPTH = 16;

  localparam logic [1:0] F_IDLE = 2'd0;  // waiting for a byte and a ready serializer
  localparam logic [1:0] F_REQ  = 2'd1;  // tx_send held high, waiting for tx_ready to fall
  localparam logic [1:0] F_REL  = 2'd2;  // byte taken, waiting for tx_ready to return

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: register-array byte queue with AW-bit wrapping pointers and an AW+1 bit count.
// Latency: a push at edge N is visible as head/count after edge N; head is read combinationally at rd_ptr.
// Backpressure: push while full is ignored (full is taken before any same-cycle pop); pop while empty is ignored.
// Ports: clk, reset (async, active-high), push/push_data, pop, full, empty, count, head.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic [7:0]    head
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];

  // Full is judged on the registered count, so a push into a full queue is
  // dropped even when a pop frees a slot on the same edge.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset. With count < DEPTH the write slot wr_ptr never
  // equals rd_ptr of a non-empty queue, so head is never overwritten in place.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART serializer through a level-held send / ready handshake.
// Latency: write into an empty FIFO at edge N with an idle, ready serializer raises tx_send after edge N+1.
// Backpressure: writes when full are dropped and set sticky overflow; tx_send waits for tx_ready high.
// Ports: clk, reset (async, active-high), wr_data/wr_en, full, empty, count, overflow, ovf_clear,
//        tx_ready (serializer ready), tx_data/tx_send (registered request to serializer).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    wr_data,
  input  logic          wr_en,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  input  logic          ovf_clear,
  input  logic          tx_ready,
  output logic [7:0]    tx_data,
  output logic          tx_send
);

  logic [1:0] state_q, state_d;
  logic       tx_send_q, tx_send_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       overflow_q, overflow_d;
  logic       fifo_pop;
  logic [7:0] fifo_head;

  byte_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_byte_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head      (fifo_head)
  );

  // Handshake: request only from idle with ready high; the byte is popped when
  // the serializer drops ready, and a new request waits for ready to return.
  always_comb begin
    state_d   = state_q;
    tx_send_d = tx_send_q;
    tx_data_d = tx_data_q;
    fifo_pop  = 1'b0;
    case (state_q)
      F_IDLE: begin
        if (!empty && tx_ready) begin
          tx_send_d = 1'b1;
          tx_data_d = fifo_head;
          state_d   = F_REQ;
        end else begin
          tx_send_d = 1'b0;
        end
      end
      F_REQ: begin
        if (!tx_ready) begin
          tx_send_d = 1'b0;
          fifo_pop  = 1'b1;
          state_d   = F_REL;
        end
      end
      F_REL: begin
        tx_send_d = 1'b0;
        if (tx_ready) state_d = F_IDLE;
      end
      default: begin
        tx_send_d = 1'b0;
        state_d   = F_IDLE;
      end
    endcase
  end

  // A dropped write outranks a coincident clear.
  always_comb begin
    overflow_d = overflow_q;
    if (wr_en && full)  overflow_d = 1'b1;
    else if (ovf_clear) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= F_IDLE;
      tx_send_q  <= 1'b0;
      tx_data_q  <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_send_q  <= tx_send_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx_send  = tx_send_q;
  assign tx_data  = tx_data_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo with a queue-based reference model
// and a randomized serializer model driving tx_ready.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    wr_data;
  logic          wr_en;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          ovf_clear;
  logic          tx_ready;
  logic [7:0]    tx_data;
  logic          tx_send;

  int n_checks = 0;
  int n_pass   = 0;
  int proto_err = 0;

  logic [7:0] exp_q[$];       // bytes the FIFO should hold, oldest first
  logic [7:0] rx_q[$];        // bytes the serializer model actually took
  logic [7:0] model_rx_q[$];  // bytes the model says should have been taken
  bit         ovf_m = 1'b0;

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .ovf_clear (ovf_clear),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_send   (tx_send)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // One clock: drive inputs, step the edge, advance the reference model.
  task automatic cycle(input logic we, input logic [7:0] wd, input logic rdy, input logic clr);
    logic       s_pre;
    logic [7:0] d_pre;
    int         sz;
    bit         acc;
    wr_en = we; wr_data = wd; tx_ready = rdy; ovf_clear = clr;
    s_pre = tx_send; d_pre = tx_data; sz = exp_q.size();
    @(posedge clk); #1;
    acc = we && (sz < DEPTH);
    if (s_pre && !rdy) begin
      rx_q.push_back(d_pre);
      model_rx_q.push_back(exp_q.pop_front());
    end
    if (acc) exp_q.push_back(wd);
    if (we && !acc) ovf_m = 1'b1;
    else if (clr)   ovf_m = 1'b0;
    if (!s_pre && tx_send && !rdy) proto_err++;
    if (s_pre && tx_send && (tx_data !== d_pre)) proto_err++;
    if (!s_pre && tx_send && (exp_q.size() == 0 || tx_data !== exp_q[0])) proto_err++;
  endtask

  // Serializer model: holds ready a random time after a request, then
  // re-raises it after a random gap.
  task automatic serve_cycle(input logic we, input logic [7:0] wd);
    logic rdy;
    if (tx_send)        rdy = tx_ready && ($urandom_range(0, 2) != 0);
    else if (!tx_ready) rdy = ($urandom_range(0, 1) == 1);
    else                rdy = 1'b1;
    cycle(we, wd, rdy, 1'b0);
  endtask

  task automatic drain(input int budget, output bit ok);
    int n = 0;
    while (!(exp_q.size() == 0 && tx_ready && !tx_send) && n < budget) begin
      serve_cycle(1'b0, 8'h00);
      n++;
    end
    ok = (exp_q.size() == 0 && tx_ready && !tx_send);
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; ovf_clear = 1'b0; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (tx_send !== 1'b0)  $display("FAIL reset_tx_send got=%b exp=0", tx_send); else n_pass++;
    n_checks++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data got=%h exp=00", tx_data); else n_pass++;
    n_checks++; if (count !== '0)      $display("FAIL reset_count got=%0d exp=0", count); else n_pass++;
    n_checks++; if (empty !== 1'b1 || full !== 1'b0)
      $display("FAIL reset_flags got empty=%b full=%b exp empty=1 full=0", empty, full); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", overflow); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    cycle(1'b1, 8'h41, 1'b1, 1'b0);
    n_checks++; if (count !== 5'd1 || tx_send !== 1'b0)
      $display("FAIL basic_write got count=%0d send=%b exp count=1 send=0", count, tx_send); else n_pass++;
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++; if (tx_send !== 1'b1 || tx_data !== 8'h41)
      $display("FAIL basic_latency got send=%b data=%h exp send=1 data=41", tx_send, tx_data); else n_pass++;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++; if (tx_send !== 1'b0 || count !== 5'd0)
      $display("FAIL basic_accept got send=%b count=%0d exp send=0 count=0", tx_send, count); else n_pass++;
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_overflow_order();
    int base;
    int ff_seen = 0;
    bit ok;
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    n_checks++; if (full !== 1'b1 || count !== 5'd16)
      $display("FAIL ovf_full got full=%b count=%0d exp full=1 count=16", full, count); else n_pass++;
    cycle(1'b1, 8'hFF, 1'b0, 1'b0);
    n_checks++; if (overflow !== 1'b1 || count !== 5'd16)
      $display("FAIL ovf_drop got ovf=%b count=%0d exp ovf=1 count=16", overflow, count); else n_pass++;
    base = rx_q.size();
    drain(1000, ok);
    n_checks++; if (!ok) $display("FAIL ovf_drain_timeout got=stuck exp=drained"); else n_pass++;
    n_checks++; if (rx_q.size() - base !== 16)
      $display("FAIL ovf_rx_count got=%0d exp=16", rx_q.size() - base); else n_pass++;
    for (int i = 0; i < 16 && base + i < rx_q.size(); i++) begin
      n_checks++; if (rx_q[base+i] !== 8'(i))
        $display("FAIL ovf_order idx=%0d got=%h exp=%h", i, rx_q[base+i], 8'(i)); else n_pass++;
    end
    for (int i = base; i < rx_q.size(); i++) if (rx_q[i] === 8'hFF) ff_seen++;
    n_checks++; if (ff_seen !== 0) $display("FAIL ovf_dropped_byte_seen got=%0d exp=0", ff_seen); else n_pass++;
  endtask

  task automatic test_ovf_clear();
    bit ok;
    n_checks++; if (overflow !== 1'b1) $display("FAIL clr_sticky got=%b exp=1", overflow); else n_pass++;
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    n_checks++; if (overflow !== 1'b0) $display("FAIL clr_pulse got=%b exp=0", overflow); else n_pass++;
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 8'hAA, 1'b0, 1'b1);
    n_checks++; if (overflow !== 1'b1 || count !== 5'd16)
      $display("FAIL clr_set_wins got ovf=%b count=%0d exp ovf=1 count=16", overflow, count); else n_pass++;
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++; if (overflow !== ovf_m) $display("FAIL clr_again got=%b exp=%b", overflow, ovf_m); else n_pass++;
    drain(1000, ok);
    n_checks++; if (!ok) $display("FAIL clr_drain_timeout got=stuck exp=drained"); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int base;
    int idx = 0;
    int n = 0;
    bit ok;
    logic [7:0] sent[$];
    logic [7:0] d;
    bit we;
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++; if (tx_send !== 1'b1 || count !== 5'd5)
      $display("FAIL b2b_req got send=%b count=%0d exp send=1 count=5", tx_send, count); else n_pass++;
    cycle(1'b1, 8'h25, 1'b0, 1'b0);
    n_checks++; if (count !== 5'd5) $display("FAIL b2b_push_pop_count got=%0d exp=5", count); else n_pass++;
    drain(1000, ok);
    n_checks++; if (!ok) $display("FAIL b2b_drain_timeout got=stuck exp=drained"); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (rx_q[rx_q.size()-6+i] !== 8'(8'h20 + i))
        $display("FAIL b2b_order idx=%0d got=%h exp=%h", i, rx_q[rx_q.size()-6+i], 8'(8'h20 + i)); else n_pass++;
    end
    // Stream 40 bytes through a 16-deep queue so both pointers wrap.
    base = rx_q.size();
    while ((idx < 40 || !(exp_q.size() == 0 && tx_ready && !tx_send)) && n < 3000) begin
      we = (idx < 40) && (exp_q.size() < DEPTH) && ($urandom_range(0, 3) != 0);
      d  = 8'($urandom);
      if (we) begin sent.push_back(d); idx++; end
      serve_cycle(we, d);
      n++;
      n_checks++; if (int'(count) !== exp_q.size())
        $display("FAIL stream_count cyc=%0d got=%0d exp=%0d", n, count, exp_q.size()); else n_pass++;
    end
    n_checks++; if (rx_q.size() - base !== 40)
      $display("FAIL stream_rx_count got=%0d exp=40", rx_q.size() - base); else n_pass++;
    for (int i = 0; i < 40 && base + i < rx_q.size() && i < sent.size(); i++) begin
      n_checks++; if (rx_q[base+i] !== sent[i])
        $display("FAIL stream_order idx=%0d got=%h exp=%h", i, rx_q[base+i], sent[i]); else n_pass++;
    end
  endtask

  task automatic test_rel_hold();
    int bad = 0;
    cycle(1'b1, 8'h61, 1'b1, 1'b0);
    cycle(1'b1, 8'h62, 1'b1, 1'b0);
    n_checks++; if (tx_send !== 1'b1 || tx_data !== 8'h61)
      $display("FAIL rel_req got send=%b data=%h exp send=1 data=61", tx_send, tx_data); else n_pass++;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
      if (tx_send !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL rel_hold_send got=%0d high cycles exp=0", bad); else n_pass++;
    n_checks++; if (count !== 5'd1) $display("FAIL rel_hold_count got=%0d exp=1", count); else n_pass++;
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++; if (tx_send !== 1'b0)
      $display("FAIL rel_no_req_from_rel got=%b exp=0", tx_send); else n_pass++;
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++; if (tx_send !== 1'b1 || tx_data !== 8'h62)
      $display("FAIL rel_next_req got send=%b data=%h exp send=1 data=62", tx_send, tx_data); else n_pass++;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++; if (count !== 5'd0) $display("FAIL rel_final_count got=%0d exp=0", count); else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++; if (tx_send !== 1'b1 || count !== 5'd3)
      $display("FAIL rstmid_pre got send=%b count=%0d exp send=1 count=3", tx_send, count); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++; if (tx_send !== 1'b0 || count !== 5'd0 || empty !== 1'b1)
      $display("FAIL rstmid_async got send=%b count=%0d empty=%b exp 0/0/1", tx_send, count, empty); else n_pass++;
    exp_q.delete();
    ovf_m = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    n_checks++; if (count !== 5'd1) $display("FAIL rstmid_write got=%0d exp=1", count); else n_pass++;
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++; if (tx_send !== 1'b1 || tx_data !== 8'h55)
      $display("FAIL rstmid_send got send=%b data=%h exp send=1 data=55", tx_send, tx_data); else n_pass++;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++; if (rx_q[$] !== 8'h55 || count !== 5'd0)
      $display("FAIL rstmid_rx got=%h count=%0d exp=55 count=0", rx_q[$], count); else n_pass++;
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_consistency();
    int diff = 0;
    n_checks++; if (proto_err !== 0) $display("FAIL protocol_violations got=%0d exp=0", proto_err); else n_pass++;
    n_checks++; if (rx_q.size() !== model_rx_q.size())
      $display("FAIL model_rx_len got=%0d exp=%0d", rx_q.size(), model_rx_q.size()); else n_pass++;
    for (int i = 0; i < rx_q.size() && i < model_rx_q.size(); i++) if (rx_q[i] !== model_rx_q[i]) diff++;
    n_checks++; if (diff !== 0) $display("FAIL model_rx_bytes got=%0d differing exp=0", diff); else n_pass++;
    n_checks++; if (overflow !== ovf_m) $display("FAIL model_overflow got=%b exp=%b", overflow, ovf_m); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow_order();
    test_ovf_clear();
    test_back_to_back();
    test_rel_hold();
    test_reset_mid();
    test_consistency();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
